// File: rtl/serial_comparator.sv
`default_nettype none
// ============================================================================
// Module      : serial_comparator
// Description : Compares two unsigned WIDTH-bit operands two bits per cycle,
//               most-significant slice first, and reports lt / eq / gt with a
//               one-cycle done pulse.
// Option      : define SERIAL_COMPARATOR_EARLY_EXIT_EN to finish on the first
//               differing slice instead of always scanning every slice.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int c_SLICES = WIDTH / 2;
  localparam int c_IDX_W  = (c_SLICES > 1) ? $clog2(c_SLICES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [c_IDX_W-1:0] r_idx;
  logic               r_decided;
  logic               r_lt;
  logic               r_eq;
  logic               r_gt;

  // Operands are shifted left each cycle, so the slice under test is always
  // the top two bits; r_idx only tracks how many slices remain.
  logic [1:0] w_slice_a;
  logic [1:0] w_slice_b;
  logic       w_diff;
  logic       w_last;

  assign w_slice_a = r_a[WIDTH-1 -: 2];
  assign w_slice_b = r_b[WIDTH-1 -: 2];
  assign w_diff    = (w_slice_a != w_slice_b);
  assign w_last    = (r_idx == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; start is only looked at while idle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = COMPARE;
        end
      end
      COMPARE: begin
        if (w_last) begin
          w_next_state = DONE;
        end
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
        // Nothing has been decided yet while still in COMPARE here, so the
        // first difference seen is the most-significant one.
        else if (w_diff) begin
          w_next_state = DONE;
        end
`endif
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Operand capture, slice scan and result recording.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_decided <= 1'b0;
      r_lt      <= 1'b0;
      r_eq      <= 1'b0;
      r_gt      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a       <= a;
            r_b       <= b;
            r_idx     <= c_IDX_W'(c_SLICES - 1);
            r_decided <= 1'b0;
            r_lt      <= 1'b0;
            r_eq      <= 1'b0;
            r_gt      <= 1'b0;
          end
        end
        COMPARE: begin
          r_a   <= r_a << 2;
          r_b   <= r_b << 2;
          r_idx <= r_idx - 1'b1;
          if (!r_decided && w_diff) begin
            // First differing slice from the top settles the result.
            r_lt      <= (w_slice_a < w_slice_b);
            r_gt      <= (w_slice_a > w_slice_b);
            r_decided <= 1'b1;
          end else if (w_last && !r_decided) begin
            r_eq <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign lt   = r_lt;
  assign eq   = r_eq;
  assign gt   = r_gt;

endmodule
`default_nettype wire

// File: tb/tb_serial_comparator.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_comparator
// Description : Directed self-checking bench for serial_comparator, WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_comparator;

  localparam int c_WIDTH = 8;
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
  localparam int c_EARLY = 1;
`else
  localparam int c_EARLY = 0;
`endif

  logic               clk;
  logic               rst;
  logic               start;
  logic [c_WIDTH-1:0] a;
  logic [c_WIDTH-1:0] b;
  logic               busy;
  logic               done;
  logic               lt;
  logic               eq;
  logic               gt;

  int n_assert = 0;
  int n_fail   = 0;

  serial_comparator #(.WIDTH(c_WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .lt    (lt),
    .eq    (eq),
    .gt    (gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares an observed vector against its expected value.
  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called in cycle 1 of an operation: walks to the done cycle, then checks
  // the return to idle with the result held. res = {lt,eq,gt}.
  task automatic wait_result(input string tag, input int lat, input logic [2:0] res);
    for (int c = 1; c <= lat; c++) begin
      if (c < lat) begin
        check({tag, "_busy"}, {busy, done, 3'b000}, {1'b1, 1'b0, 3'b000});
      end else begin
        check({tag, "_done"}, {busy, done, lt, eq, gt}, {1'b1, 1'b1, res});
      end
      @(negedge clk);
    end
    check({tag, "_idle"}, {busy, done, lt, eq, gt}, {1'b0, 1'b0, res});
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset: everything low for three cycles.
    for (int i = 0; i < 3; i++) begin
      check("reset_idle", {busy, done, lt, eq, gt}, 5'b00000);
      @(negedge clk);
    end

    // Equal operands: eq, five-cycle latency in both builds, held afterwards.
    start = 1'b1; a = 8'h5A; b = 8'h5A;
    @(negedge clk);
    start = 1'b0; a = 8'hFF; b = 8'h00;
    wait_result("eq_5a", 5, 3'b010);
    @(negedge clk);
    @(negedge clk);
    check("eq_held", {busy, done, lt, eq, gt}, 5'b00010);

    // Top slice differs: gt, early exit finishes in cycle 2.
    start = 1'b1; a = 8'h80; b = 8'h7F;
    @(negedge clk);
    start = 1'b0;
    wait_result("gt_80_7f", c_EARLY ? 2 : 5, 3'b001);

    // Only the bottom slice differs: lt, five cycles in both builds.
    start = 1'b1; a = 8'h12; b = 8'h13;
    @(negedge clk);
    start = 1'b0;
    wait_result("lt_12_13", 5, 3'b100);

    // start held high and operands changed while busy.
    start = 1'b1; a = 8'h40; b = 8'h3F;
    @(negedge clk);
    a = 8'h00; b = 8'h00;
    for (int c = 1; c <= (c_EARLY ? 2 : 5); c++) begin
      if (c == (c_EARLY ? 2 : 5)) begin
        check("hold_done", {busy, done, lt, eq, gt}, 5'b11001);
      end else begin
        check("hold_busy", {busy, done, 3'b000}, 5'b10000);
      end
      @(negedge clk);
    end
    check("hold_idle", {busy, done, lt, eq, gt}, 5'b00001);
    @(negedge clk);
    // Second operation was accepted only from IDLE, with the new operands.
    start = 1'b0;
    check("hold_restart", {busy, done, lt, eq, gt}, 5'b10000);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
    end
    check("hold_second_done", {busy, done, lt, eq, gt}, 5'b11010);
    @(negedge clk);
    check("hold_second_idle", {busy, done, lt, eq, gt}, 5'b00010);

    // Abort by reset in the second COMPARE cycle.
    start = 1'b1; a = 8'hFF; b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    check("abort_c1", {busy, done, 3'b000}, 5'b10000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_rst", {busy, done, lt, eq, gt}, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_quiet", {busy, done, lt, eq, gt}, 5'b00000);
    end
    start = 1'b1; a = 8'h01; b = 8'h02;
    @(negedge clk);
    start = 1'b0;
    wait_result("lt_01_02", 5, 3'b100);

    // Reset overrides start; start on the first edge after release is taken.
    rst = 1'b1; start = 1'b1; a = 8'h03; b = 8'h01;
    @(negedge clk);
    check("rst_over_start", {busy, done, lt, eq, gt}, 5'b00000);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_result("gt_03_01", 5, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; SHALL be even and >= 2.
REQ-002 Derived constant: SLICES = WIDTH/2, the number of 2-bit slices compared MSB-first.
REQ-003 Port: clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request; SHALL be sampled only in IDLE.
REQ-006 Port: a  input  WIDTH  operand A; SHALL be latched on an accepted start.
REQ-007 Port: b  input  WIDTH  operand B; SHALL be latched on an accepted start.
REQ-008 Port: busy  output  1  high while in COMPARE or DONE.
REQ-009 Port: done  output  1  one-cycle pulse marking a valid result.
REQ-010 Port: lt  output  1  registered result, A < B (unsigned).
REQ-011 Port: eq  output  1  registered result, A == B.
REQ-012 Port: gt  output  1  registered result, A > B (unsigned).

Function
REQ-013 Three states SHALL exist: IDLE, COMPARE and DONE.
REQ-014 IDLE with start=1 SHALL, at the next edge:
  - latch a and b;
  - set the slice index to SLICES-1;
  - clear lt, eq and gt to 0;
  - clear the internal "decided" flag;
  - enter COMPARE.
REQ-015 In COMPARE, each cycle SHALL compare slice {A[2i+1],A[2i]} against {B[2i+1],B[2i]} as 2-bit unsigned values.
REQ-016 If a slice differs and "decided" is clear, the block SHALL record lt or gt and set "decided".
REQ-017 Once "decided" is set, all later slices SHALL be ignored, so the result is always set by the most-significant differing slice.
REQ-018 After slice 0 is evaluated, the next state SHALL be DONE.
REQ-019 If no slice differed, eq SHALL be set on entry to DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 After DONE, exactly one of lt, eq and gt SHALL be 1, held until the next accepted start or reset.
REQ-022 start SHALL be ignored while busy=1, including during the DONE cycle; a and b changes while busy SHALL have no effect.
REQ-023 busy SHALL rise on the edge that accepts start and SHALL fall on the edge leaving DONE.
REQ-024 Latency without early exit: done SHALL be high in cycle SLICES+1 after the start-sampling edge (cycle 5 for WIDTH=8), independent of the data.
REQ-025 WIDTH=2 SHALL work with a single COMPARE cycle.

Reset
REQ-026 rst=1 at an edge SHALL force state IDLE and clear busy, done, lt, eq, gt and the "decided" flag to 0, overriding start.
REQ-027 rst asserted during COMPARE or DONE SHALL abort the operation; no done pulse SHALL follow and the outputs SHALL read 0 until a new comparison completes.
REQ-028 start sampled on the first edge after rst deasserts SHALL be accepted normally.

Configuration
REQ-029 Macro: SERIAL_COMPARATOR_EARLY_EXIT_EN.
REQ-030 With the macro defined, COMPARE SHALL go to DONE on the edge that records the first differing slice, so latency = (slices evaluated)+1 cycles; equal operands still take SLICES+1 cycles.
REQ-031 With the macro undefined, latency SHALL always be SLICES+1 cycles (REQ-024).
REQ-032 Result values SHALL be identical in both builds.

Verification (WIDTH=8)
REQ-033 Reset, then idle for 3 cycles -> busy=done=lt=eq=gt=0 throughout.
REQ-034 a=0x5A, b=0x5A, start for 1 cycle -> done pulse 5 cycles later with eq=1, lt=gt=0, both builds; held until the next start.
REQ-035 a=0x80, b=0x7F -> gt=1; done at cycle 5 without the macro, cycle 2 with it.
REQ-036 a=0x12, b=0x13 (differ in LSB slice only) -> lt=1, done at cycle 5 in both builds.
REQ-037 a=0x40, b=0x3F, with start held high and a/b changed to 0x00 during busy -> a single result, gt=1; the next comparison starts only after return to IDLE.
REQ-038 a=0xFF, b=0x00, rst pulsed in the 2nd COMPARE cycle -> no done pulse, all outputs 0; a following start with a=0x01, b=0x02 -> lt=1.
